// File: rtl/left_shift_ctrl.sv
// MSB-first parallel-to-serial left-shift controller (IDLE -> SHIFT -> DONE).
// Define LEFT_SHIFT_CTRL_PAUSE_EN to add the pause stall input.
module left_shift_ctrl #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          sync_rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          fill,
  output logic [DW-1:0] q,
  output logic          sdo,
  output logic          sdo_valid,
  output logic          done,
  output logic          busy
`ifdef LEFT_SHIFT_CTRL_PAUSE_EN
  ,
  input  logic          pause
`endif
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] q_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          stall;

`ifdef LEFT_SHIFT_CTRL_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      q     <= q_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          q_n     = in_data;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (!stall) begin
          q_n   = {q[DW-2:0], fill};
          cnt_n = cnt + 1'b1;
          if (cnt == CW'(DW-1))
            state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs come from registered state only.
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign sdo_valid = (state == SHIFT) && !stall;
  assign sdo       = q[DW-1];

endmodule

// File: tb/tb_left_shift_ctrl.sv
// Scoreboard bench for left_shift_ctrl (DW=4): stimulus pushes expected
// stream bits and done pulses, a negedge monitor pops and compares.
module tb_left_shift_ctrl;

  logic       clk = 1'b0;
  logic       sync_rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       fill;
  logic [3:0] q;
  logic       sdo;
  logic       sdo_valid;
  logic       done;
  logic       busy;
`ifdef LEFT_SHIFT_CTRL_PAUSE_EN
  logic       pause;
`endif

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  bit exp_bits[$];
  int exp_done[$];

  always #5 clk = ~clk;

  left_shift_ctrl #(.DW(4)) dut (
    .clk       (clk),
    .sync_rst_n(sync_rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .fill      (fill),
    .q         (q),
    .sdo       (sdo),
    .sdo_valid (sdo_valid),
    .done      (done),
    .busy      (busy)
`ifdef LEFT_SHIFT_CTRL_PAUSE_EN
    ,
    .pause     (pause)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) exp_bits.push_back(w[i]);
  endtask

  // Monitor: every valid stream bit and done pulse must match the queues.
  always @(negedge clk) begin
    if (started) begin
      if (sdo_valid) begin
        if (exp_bits.size() == 0) begin
          chk("unexpected_sdo_valid", 1, 0);
        end else begin
          chk("sdo_bit", int'(sdo), int'(exp_bits.pop_front()));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          void'(exp_done.pop_front());
          chk("done_busy", int'(busy), 1);
        end
      end
    end
  end

  logic [3:0] qseq [4];

  initial begin
    qseq = '{4'b0110, 4'b1100, 4'b1000, 4'b0000};
    sync_rst_n = 1'b0;
    in_valid   = 1'b1;
    in_data    = 4'b1111;
    fill       = 1'b1;
`ifdef LEFT_SHIFT_CTRL_PAUSE_EN
    pause      = 1'b0;
`endif
    step();
    step();
    sync_rst_n = 1'b1;
    in_valid   = 1'b0;
    @(negedge clk);
    chk("rst_q", int'(q), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sdo", int'(sdo), 0);
    chk("rst_sdo_valid", int'(sdo_valid), 0);
    started = 1'b1;

    // Basic frame 1011, fill=0.
    in_valid = 1'b1;
    in_data  = 4'b1011;
    fill     = 1'b0;
    push_word(4'b1011);
    exp_done.push_back(1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("shift_in_ready", int'(in_ready), 0);
    chk("shift_busy", int'(busy), 1);
    chk("first_q", int'(q), 11);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("q_shift", int'(q), int'(qseq[i]));
    end
    chk("done_5th", int'(done), 1);
    chk("done_in_ready", int'(in_ready), 0);
    step();
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);

    // Zero word with fill=1.
    in_valid = 1'b1;
    in_data  = 4'b0000;
    fill     = 1'b1;
    push_word(4'b0000);
    exp_done.push_back(2);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("fill_q", int'(q), 15);
    chk("fill_done", int'(done), 1);
    step();

    // Held in_valid is ignored until IDLE.
    in_valid = 1'b1;
    in_data  = 4'b1011;
    fill     = 1'b0;
    push_word(4'b1011);
    push_word(4'b0101);
    exp_done.push_back(3);
    exp_done.push_back(4);
    step();
    in_data = 4'b0101;
    repeat (5) step();
    @(negedge clk);
    chk("hold_in_ready", int'(in_ready), 1);
    chk("hold_q_ignored", int'(q), 0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("hold_accept_q", int'(q), 5);
    chk("hold_accept_busy", int'(busy), 1);
    repeat (5) step();

    // Reset on the 2nd SHIFT cycle aborts the frame.
    in_valid = 1'b1;
    in_data  = 4'b1011;
    exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b0);
    step();
    in_valid = 1'b0;
    step();
    sync_rst_n = 1'b0;
    step();
    sync_rst_n = 1'b1;
    @(negedge clk);
    chk("abort_q", int'(q), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_busy", int'(busy), 0);
    repeat (6) step();

`ifdef LEFT_SHIFT_CTRL_PAUSE_EN
    // Two-cycle pause stretches the frame to six SHIFT cycles.
    in_valid = 1'b1;
    in_data  = 4'b1011;
    push_word(4'b1011);
    exp_done.push_back(5);
    step();
    in_valid = 1'b0;
    step();
    step();
    pause = 1'b1;
    @(negedge clk);
    chk("pause_valid0", int'(sdo_valid), 0);
    chk("pause_busy", int'(busy), 1);
    step();
    @(negedge clk);
    chk("pause_valid1", int'(sdo_valid), 0);
    step();
    pause = 1'b0;
    step();
    @(negedge clk);
    chk("pause_not_done", int'(done), 0);
    step();
    @(negedge clk);
    chk("pause_done", int'(done), 1);
    step();
`endif

    repeat (2) step();
    chk("bits_drained", exp_bits.size(), 0);
    chk("dones_drained", exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/left_shift_ctrl.md
LEFT_SHIFT_CTRL -- requirements
Module: left_shift_ctrl

Interface
REQ-001 Parameter: DW, default 4, word width in bits; SHALL be >= 2.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 sync_rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  parallel word offered.
REQ-005 in_data  input  DW  parallel word to serialize.
REQ-006 in_ready  output  1  controller can accept a word this cycle.
REQ-007 fill  input  1  bit shifted into the register LSB on each shift.
REQ-008 q  output  DW  internal left-shift register contents.
REQ-009 sdo  output  1  serial data out, equal to q[DW-1].
REQ-010 sdo_valid  output  1  sdo carries a valid stream bit this cycle.
REQ-011 done  output  1  one-cycle pulse after the last bit of a frame.
REQ-012 busy  output  1  frame in progress (state SHIFT or DONE).
REQ-013 pause  input  1  shift stall; present only when LEFT_SHIFT_CTRL_PAUSE_EN is defined.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-015 IDLE: in_ready=1, sdo_valid=0, done=0, busy=0; q holds.
REQ-016 In IDLE, in_valid=1 at a clk edge SHALL load q<=in_data, clear the bit counter, and enter SHIFT.
REQ-017 SHIFT: in_ready=0, busy=1, sdo_valid=1; each edge SHALL set q<={q[DW-2:0],fill} and increment the counter.
REQ-018 The bit counter SHALL be $clog2(DW) bits wide; the edge with counter==DW-1 SHALL enter DONE, so SHIFT lasts exactly DW cycles.
REQ-019 Stream order is MSB-first: in stream cycle i (0-based), sdo SHALL equal in_data[DW-1-i].
REQ-020 Latency: the first sdo_valid cycle SHALL be the cycle immediately after the accepting edge.
REQ-021 DONE: exactly one cycle with done=1, busy=1, in_ready=0, sdo_valid=0; then IDLE.
REQ-022 Word period SHALL be DW+2 cycles (accept, DW shifts, DONE); no back-to-back acceptance.
REQ-023 in_valid while in SHIFT or DONE SHALL be ignored with no state change; the source holds the word until in_ready=1.
REQ-024 Outputs SHALL be decoded from registered state and q only, with no combinational path from in_valid to in_ready.

Reset
REQ-025 With sync_rst_n=0 at a clk edge, the block SHALL enter IDLE with q=0 and counter=0; resulting outputs: in_ready=1, sdo=0, sdo_valid=0, done=0, busy=0.
REQ-026 Reset SHALL dominate in_valid, pause and all FSM transitions.
REQ-027 Reset during SHIFT or DONE SHALL abort the frame with no done pulse.

Configuration
REQ-028 Macro LEFT_SHIFT_CTRL_PAUSE_EN defined: port pause SHALL exist.
REQ-029 With the macro defined, pause=1 in SHIFT SHALL hold q and the counter and force sdo_valid=0; pause SHALL be ignored in IDLE and DONE.
REQ-030 Macro undefined: port pause SHALL be absent, and SHIFT SHALL advance every cycle.

Verification (DW=4)
REQ-031 sync_rst_n=0 for 2 cycles from random state -> q=0000, in_ready=1, busy=0, done=0.
REQ-032 in_data=1011 accepted, fill=0 -> sdo=1,0,1,1 with sdo_valid=1 on 4 consecutive cycles; q goes 0110, 1100, 1000, 0000; done=1 on the 5th cycle; in_ready=1 on the 6th cycle.
REQ-033 in_data=0000 accepted, fill=1 -> q=1111 after the 4 shifts, sdo all 0.
REQ-034 in_data=1011 accepted, then in_valid=1 with in_data=0101 held throughout -> 0101 ignored during SHIFT and DONE; accepted at the first IDLE edge; next stream is 0,1,0,1.
REQ-035 sync_rst_n=0 on the 2nd SHIFT cycle -> IDLE and q=0000 next cycle; done never pulses.
REQ-036 (Macro defined) pause=1 for 2 cycles after stream bit 1 -> sdo_valid low 2 cycles, frame spans 6 cycles, bits still 1,0,1,1.
